// File: rtl/traffic_pkg.sv
// Shared types and defaults for the countdown timer slice.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int COUNT_MAX_DEFAULT = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running cycle divider; emits a one-cycle tick on the wrap from TICK_CYCLES-1 to 0.
module tick_prescaler #(
  parameter int TICK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown with start/pause/abort control; counter, running and expired are registered.
module countdown_timer
  import traffic_pkg::*;
#(
  parameter int TICK_CYCLES = 50000000,
  parameter int COUNT_MAX   = COUNT_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] load_val,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] counter,
  output logic       running,
  output logic       expired
);

  state_t     state;
  state_t     state_next;
  logic [3:0] counter_next;
  logic       expired_next;
  logic       running_next;
  logic       load_ok;
  logic [3:0] load_clamped;
  logic       tick;
  logic       enable;
  logic       clear;

  assign load_ok      = start && (load_val != 4'd0);
  assign load_clamped = (32'(load_val) > 32'(COUNT_MAX)) ? 4'(COUNT_MAX) : load_val;

  // Any start (even an ignored zero load) or a pause pre-empts the prescaler for that cycle.
  assign enable = (state == RUN) && !abort && !start && !pause;
  assign clear  = abort || load_ok;

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .enable(enable),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    expired_next = 1'b0;
    if (abort) begin
      state_next   = IDLE;
      counter_next = 4'd0;
    end else if (load_ok) begin
      state_next   = RUN;
      counter_next = load_clamped;
    end else if (!start) begin
      case (state)
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (tick) begin
            if (counter > 4'd1) begin
              counter_next = counter - 4'd1;
            end else begin
              counter_next = 4'd0;
              expired_next = 1'b1;
              state_next   = IDLE;
            end
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next   = IDLE;
          counter_next = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    running_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= 4'd0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      counter <= counter_next;
      running <= running_next;
      expired <= expired_next;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed checks of countdown_timer against a seconds-level reference model.
module tb_countdown_timer;

  localparam int TICKS = 4;
  localparam int CMAX  = 10;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] load_val;
  logic       pause;
  logic       abort;
  logic [3:0] counter;
  logic       running;
  logic       expired;

  int vectors;
  int miscompares;

  // Reference model: remaining seconds, cycles elapsed in the current second, mode flags.
  int m_count;
  int m_phase;
  bit m_run;
  bit m_paused;
  bit m_expired;
  int expired_seen;

  countdown_timer #(
    .TICK_CYCLES(TICKS),
    .COUNT_MAX  (CMAX)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .load_val(load_val),
    .pause   (pause),
    .abort   (abort),
    .counter (counter),
    .running (running),
    .expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_count   = 0;
    m_phase   = 0;
    m_run     = 0;
    m_paused  = 0;
    m_expired = 0;
  endtask

  task automatic modelStep(input bit s, input int lv, input bit p, input bit a);
    m_expired = 0;
    if (a) begin
      modelReset();
    end else if (s && lv != 0) begin
      m_count  = (lv > CMAX) ? CMAX : lv;
      m_phase  = 0;
      m_run    = 1;
      m_paused = 0;
    end else if (s) begin
      // zero load: whole cycle ignored
    end else if (m_run && !m_paused) begin
      if (p) begin
        m_paused = 1;
      end else begin
        m_phase++;
        if (m_phase == TICKS) begin
          m_phase = 0;
          m_count--;
          if (m_count == 0) begin
            m_run     = 0;
            m_expired = 1;
          end
        end
      end
    end else if (m_paused && !p) begin
      m_paused = 0;
    end
  endtask

  task automatic applyStimulus(input bit s, input logic [3:0] lv, input bit p, input bit a);
    start    = s;
    load_val = lv;
    pause    = p;
    abort    = a;
    @(posedge clk);
    modelStep(s, int'(lv), p, a);
    #1;
    if (expired === 1'b1) expired_seen++;
    checkOutput("counter", 32'(counter), 32'(m_count));
    checkOutput("running", 32'(running), 32'(m_run));
    checkOutput("expired", 32'(expired), 32'(m_expired));
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    expired_seen = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    load_val = 4'd0;
    pause    = 1'b0;
    abort    = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_counter", 32'(counter), 32'd0);
    checkOutput("reset_running", 32'(running), 32'd0);
    checkOutput("reset_expired", 32'(expired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] load 3 and count to zero");
    expired_seen = 0;
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
    checkOutput("load3_counter", 32'(counter), 32'd3);
    idleCycles(12);
    checkOutput("load3_done", 32'(counter), 32'd0);
    checkOutput("load3_pulses", 32'(expired_seen), 32'd1);
    idleCycles(2);

    $display("[TB] pause after two decrements");
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    idleCycles(9);
    checkOutput("pre_pause", 32'(counter), 32'd3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("held_pause", 32'(counter), 32'd3);
    idleCycles(6);
    checkOutput("post_pause", 32'(counter), 32'd2);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

    $display("[TB] abort beats start");
    expired_seen = 0;
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    idleCycles(4);
    checkOutput("pre_abort", 32'(counter), 32'd4);
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b1);
    checkOutput("abort_counter", 32'(counter), 32'd0);
    checkOutput("abort_running", 32'(running), 32'd0);
    idleCycles(3);
    checkOutput("abort_pulses", 32'(expired_seen), 32'd0);

    $display("[TB] clamp and zero load");
    applyStimulus(1'b1, 4'd15, 1'b0, 1'b0);
    checkOutput("clamp", 32'(counter), 32'd10);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("zero_load_counter", 32'(counter), 32'd0);
    checkOutput("zero_load_running", 32'(running), 32'd0);

    $display("[TB] reload on final tick");
    expired_seen = 0;
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
    idleCycles(7);
    checkOutput("pre_reload", 32'(counter), 32'd1);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
    checkOutput("reload_counter", 32'(counter), 32'd7);
    checkOutput("reload_pulses", 32'(expired_seen), 32'd0);

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
    idleCycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_counter", 32'(counter), 32'd0);
    checkOutput("arst_running", 32'(running), 32'd0);
    checkOutput("arst_expired", 32'(expired), 32'd0);
    modelReset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    expired_seen = 0;
    idleCycles(8);
    checkOutput("arst_pulses", 32'(expired_seen), 32'd0);

    $display("[TB] random traffic");
    begin
      bit p_level;
      p_level = 1'b0;
      for (int i = 0; i < 600; i++) begin
        bit s;
        bit a;
        logic [3:0] lv;
        a  = ($urandom_range(0, 99) < 3);
        s  = ($urandom_range(0, 99) < 8);
        lv = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < 15) p_level = ~p_level;
        applyStimulus(s, lv, p_level, a);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000000; clock cycles per one-second decrement tick (50 MHz board clock).
REQ-002 SHALL have parameter COUNT_MAX, default 10; largest loadable count.
REQ-003 SHALL have port clk  input  1; single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1; reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1; level sampled each cycle; loads load_val and begins counting.
REQ-006 SHALL have port load_val  input  4; start value for the countdown.
REQ-007 SHALL have port pause  input  1; level; freezes counting while high.
REQ-008 SHALL have port abort  input  1; level sampled each cycle; returns to idle.
REQ-009 SHALL have port counter  output  4; current remaining seconds, registered, range 0..COUNT_MAX; drives the digit display decoder.
REQ-010 SHALL have port running  output  1; high in RUN or PAUSE.
REQ-011 SHALL have port expired  output  1; one-cycle pulse when the countdown reaches 0.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE; all outputs registered.
REQ-013 SHALL apply per-cycle priority: abort > start > pause > tick.
REQ-014 SHALL, on abort in any state, go to IDLE next cycle with counter=0, prescaler=0, no expired pulse.
REQ-015 SHALL, on start with load_val 1..COUNT_MAX in any state, set counter=load_val, prescaler=0, state RUN on the next edge (restart when already RUN/PAUSE).
REQ-016 SHALL clamp load_val > COUNT_MAX to COUNT_MAX on load.
REQ-017 SHALL ignore start with load_val=0 (state, counter, prescaler unchanged).
REQ-018 SHALL, in RUN, increment prescaler 0..TICK_CYCLES-1 and wrap to 0, asserting an internal tick on the wrap cycle.
REQ-019 SHALL, on tick with counter>1, decrement counter by 1 on the same edge as the wrap.
REQ-020 SHALL, on tick with counter=1, set counter=0, pulse expired for exactly one cycle, state IDLE.
REQ-021 SHALL make the first decrement exactly TICK_CYCLES cycles after the edge that loads the counter.
REQ-022 SHALL, in RUN with pause high, enter PAUSE; prescaler and counter hold; a tick due that cycle is suppressed.
REQ-023 SHALL, in PAUSE with pause low, return to RUN, resuming the prescaler from its held value.
REQ-024 SHALL, when start and a counter=1 tick coincide, reload and not pulse expired.
REQ-025 SHALL hold counter at 0 and prescaler at 0 in IDLE; pause has no effect in IDLE.
REQ-026 SHALL never let counter underflow below 0 or exceed COUNT_MAX.
REQ-027 SHALL size the prescaler to ceil(log2(TICK_CYCLES)) bits, with TICK_CYCLES>=2.

Reset
REQ-028 SHALL, while rst_n low, force state=IDLE, counter=0, prescaler=0, running=0, expired=0 immediately (asynchronous).
REQ-029 SHALL abandon any count in progress on reset; no expired pulse is generated by reset or its release.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-031 SHALL take the state enumeration and COUNT_MAX default from the shared package traffic_pkg.
REQ-032 SHALL place the prescaler in one sub-module, tick_prescaler (inputs clk, rst_n, clear, enable; output tick).

Verification (TICK_CYCLES=4)
REQ-033 SHALL cover: start with load_val=3 -> counter 3,2,1,0 at 4-cycle spacing; expired high one cycle with counter=0; running falls same edge.
REQ-034 SHALL cover: load 5, pause high 10 cycles after 2 decrements -> counter holds 3 throughout; release -> next decrement after remaining prescaler cycles.
REQ-035 SHALL cover: abort and start same cycle while counter=4 -> IDLE, counter=0, no expired.
REQ-036 SHALL cover: load_val=15 -> counter=10; load_val=0 in IDLE -> remains IDLE, counter=0.
REQ-037 SHALL cover: start with load_val=7 on the cycle counter=1 ticks -> counter=7, expired never asserted.
REQ-038 SHALL cover: rst_n low mid-count (counter=6) between clock edges -> outputs 0 immediately; after release idle until start.
